// File: rtl/cook_timer_pkg.sv
// Shared microwave timer definitions: state encoding, BCD digit limits and time width.
package cook_timer_pkg;

    localparam int unsigned TIME_W           = 16;
    localparam int unsigned DIGIT_W          = 4;
    localparam int unsigned BCD_DIGIT_MAX    = 9;
    localparam int unsigned BCD_SEC_TENS_MAX = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_units;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_units;
    } bcd_time_t;

endpackage

// File: rtl/cook_timer_bcd_time_dec.sv
// BCD mm:ss helper: validates a keypad value and produces the one-second decrement of a time value.
module bcd_time_dec
    import cook_timer_pkg::*;
(
    input  logic [TIME_W-1:0] check_in,
    input  logic [TIME_W-1:0] time_in,
    output logic [TIME_W-1:0] time_dec,
    output logic              valid
);

    bcd_time_t chk;
    bcd_time_t cur;
    bcd_time_t nxt;

    always_comb begin
        chk   = bcd_time_t'(check_in);
        valid = (chk.min_tens  <= DIGIT_W'(BCD_DIGIT_MAX))    &&
                (chk.min_units <= DIGIT_W'(BCD_DIGIT_MAX))    &&
                (chk.sec_tens  <= DIGIT_W'(BCD_SEC_TENS_MAX)) &&
                (chk.sec_units <= DIGIT_W'(BCD_DIGIT_MAX));
    end

    // Borrow ripples from seconds units up to minute tens; seconds tens wraps to 5.
    always_comb begin
        cur = bcd_time_t'(time_in);
        nxt = cur;
        if (cur.sec_units != '0) begin
            nxt.sec_units = cur.sec_units - DIGIT_W'(1);
        end else begin
            nxt.sec_units = DIGIT_W'(BCD_DIGIT_MAX);
            if (cur.sec_tens != '0) begin
                nxt.sec_tens = cur.sec_tens - DIGIT_W'(1);
            end else begin
                nxt.sec_tens = DIGIT_W'(BCD_SEC_TENS_MAX);
                if (cur.min_units != '0) begin
                    nxt.min_units = cur.min_units - DIGIT_W'(1);
                end else begin
                    nxt.min_units = DIGIT_W'(BCD_DIGIT_MAX);
                    nxt.min_tens  = cur.min_tens - DIGIT_W'(1);
                end
            end
        end
        time_dec = TIME_W'(nxt);
    end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: BCD mm:ss countdown with load/start/cancel control.
// Optional pause/resume support is built when COOK_TIMER_PAUSE_EN is defined.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TIME_W-1:0] durationIn,
    input  logic              load,
    input  logic              start,
    input  logic              cancel,
`ifdef COOK_TIMER_PAUSE_EN
    input  logic              pause,
`endif
    output logic [TIME_W-1:0] timeLeft,
    output logic              running,
    output logic              done,
    output logic              loadErr
);

    localparam int unsigned        PRESC_W    = $clog2(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_e              state;
    state_e              state_d;
    logic [PRESC_W-1:0]  presc;
    logic [PRESC_W-1:0]  presc_d;
    logic [TIME_W-1:0]   time_d;
    logic [TIME_W-1:0]   time_dec;
    logic                dur_valid;
    logic                load_err_d;
    logic                resumable;
    logic                loadable;

    bcd_time_dec u_dec (
        .check_in (durationIn),
        .time_in  (timeLeft),
        .time_dec (time_dec),
        .valid    (dur_valid)
    );

`ifdef COOK_TIMER_PAUSE_EN
    assign resumable = (state == ST_ARMED) || (state == ST_PAUSED);
`else
    assign resumable = (state == ST_ARMED);
`endif
    assign loadable = (state == ST_IDLE) || (state == ST_ARMED) || (state == ST_DONE);

    // State and datapath registers; outputs follow the next state so they are flopped.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            presc    <= '0;
            timeLeft <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            loadErr  <= 1'b0;
        end else begin
            state    <= state_d;
            presc    <= presc_d;
            timeLeft <= time_d;
            running  <= (state_d == ST_RUN);
            done     <= (state_d == ST_DONE);
            loadErr  <= load_err_d;
        end
    end

    // Next state: the highest-priority pulse that has an effect in the current state wins.
    always_comb begin
        state_d    = state;
        presc_d    = presc;
        time_d     = timeLeft;
        load_err_d = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            presc_d = '0;
            time_d  = '0;
`ifdef COOK_TIMER_PAUSE_EN
        end else if (pause && (state == ST_RUN)) begin
            state_d = ST_PAUSED;
`endif
        end else if (start && resumable) begin
            state_d = ST_RUN;
            presc_d = '0;
        end else if (load && loadable) begin
            if (dur_valid && (durationIn != '0)) begin
                state_d = ST_ARMED;
                time_d  = durationIn;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (state == ST_RUN) begin
            if (presc == PRESC_LAST) begin
                presc_d = '0;
                time_d  = time_dec;
                if (time_dec == '0) begin
                    state_d = ST_DONE;
                end
            end else begin
                presc_d = presc + PRESC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cook_timer.sv
// Self-checking bench for cook_timer: directed scenarios then random pulses against a seconds-based model.
module tb_cook_timer;

    localparam int unsigned TPS = 4;
    localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_PAUSED = 3, M_DONE = 4;

    logic        clock;
    logic        reset;
    logic [15:0] durationIn;
    logic        load;
    logic        start;
    logic        cancel;
    logic        pause;
    logic [15:0] timeLeft;
    logic        running;
    logic        done;
    logic        loadErr;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_mode;
    int   m_secs;
    int   m_phase;
    logic m_err;

    cook_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clock      (clock),
        .reset      (reset),
        .durationIn (durationIn),
        .load       (load),
        .start      (start),
        .cancel     (cancel),
`ifdef COOK_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .timeLeft   (timeLeft),
        .running    (running),
        .done       (done),
        .loadErr    (loadErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit bcd_ok(input logic [15:0] d);
        return (d[15:12] <= 9) && (d[11:8] <= 9) && (d[7:4] <= 5) && (d[3:0] <= 9);
    endfunction

    function automatic int to_secs(input logic [15:0] d);
        return (10 * int'(d[15:12]) + int'(d[11:8])) * 60 + 10 * int'(d[7:4]) + int'(d[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int m;
        int ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: remaining time kept as a plain count of seconds.
    task automatic model_step(input logic r, l, s, c, p, input logic [15:0] d);
        logic p_eff;
`ifdef COOK_TIMER_PAUSE_EN
        p_eff = p;
`else
        p_eff = 1'b0 & p;
`endif
        m_err = 1'b0;
        if (r) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0;
        end else if (c) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0;
        end else if (p_eff && m_mode == M_RUN) begin
            m_mode = M_PAUSED;
        end else if (s && (m_mode == M_ARMED || m_mode == M_PAUSED)) begin
            m_mode = M_RUN; m_phase = 0;
        end else if (l && m_mode != M_RUN && m_mode != M_PAUSED) begin
            if (bcd_ok(d) && d != 16'h0000) begin
                m_secs = to_secs(d); m_mode = M_ARMED;
            end else begin
                m_err = 1'b1;
            end
        end else if (m_mode == M_RUN) begin
            m_phase++;
            if (m_phase == int'(TPS)) begin
                m_phase = 0;
                m_secs--;
                if (m_secs == 0) m_mode = M_DONE;
            end
        end
    endtask

    task automatic check_model();
        chk("timeLeft", timeLeft, to_bcd(m_secs));
        chk("running", 16'(running), 16'(m_mode == M_RUN));
        chk("done", 16'(done), 16'(m_mode == M_DONE));
        chk("loadErr", 16'(loadErr), 16'(m_err));
    endtask

    task automatic cyc(input logic r, l, s, c, p, input logic [15:0] d);
        reset = r; load = l; start = s; cancel = c; pause = p; durationIn = d;
        @(posedge clock);
        model_step(r, l, s, c, p, d);
        #1;
        reset = 1'b0; load = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; start = 1'b0; cancel = 1'b0; pause = 1'b0;
        durationIn = 16'h0000;

        // Reset state
        cyc(1, 0, 0, 0, 0, 16'h0000);
        cyc(1, 0, 0, 0, 0, 16'h0000);
        chk("rst_time", timeLeft, 16'h0000);
        chk("rst_run", 16'(running), 16'h0000);

        // 3-second countdown
        cyc(0, 1, 0, 0, 0, 16'h0003);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        chk("run_after_start", 16'(running), 16'h0001);
        idle(4);  chk("t4", timeLeft, 16'h0002);
        idle(4);  chk("t8", timeLeft, 16'h0001);
        idle(4);  chk("t12", timeLeft, 16'h0000);
        chk("t12_done", 16'(done), 16'h0001);
        chk("t12_run", 16'(running), 16'h0000);
        idle(3);
        chk("done_hold", 16'(done), 16'h0001);

        // Minute and seconds borrow
        cyc(0, 0, 0, 1, 0, 16'h0000);
        cyc(0, 1, 0, 0, 0, 16'h1000);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(4);  chk("borrow_1000", timeLeft, 16'h0959);
        cyc(0, 1, 0, 0, 0, 16'h0200);
        chk("load_in_run_ignored", timeLeft, 16'h0959);
        cyc(0, 0, 0, 1, 0, 16'h0000);
        cyc(0, 1, 0, 0, 0, 16'h0100);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(4);  chk("borrow_0100", timeLeft, 16'h0059);

        // Rejected loads
        cyc(0, 0, 0, 1, 0, 16'h0000);
        cyc(0, 1, 0, 0, 0, 16'h0075);
        chk("err_0075", 16'(loadErr), 16'h0001);
        chk("err_0075_time", timeLeft, 16'h0000);
        idle(1);  chk("err_pulse_end", 16'(loadErr), 16'h0000);
        cyc(0, 1, 0, 0, 0, 16'h0005);
        cyc(0, 1, 0, 0, 0, 16'h0000);
        chk("err_0000", 16'(loadErr), 16'h0001);
        chk("err_0000_time", timeLeft, 16'h0005);
        cyc(0, 1, 0, 0, 0, 16'h1A00);
        chk("err_digit", 16'(loadErr), 16'h0001);

        // Cancel beats start
        cyc(0, 1, 0, 0, 0, 16'h0131);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(4);  chk("at_0130", timeLeft, 16'h0130);
        cyc(0, 0, 1, 1, 0, 16'h0000);
        chk("cancel_time", timeLeft, 16'h0000);
        chk("cancel_run", 16'(running), 16'h0000);

`ifdef COOK_TIMER_PAUSE_EN
        // Pause freezes time and prescaler; resume restarts the second
        cyc(0, 1, 0, 0, 0, 16'h0005);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(2);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        idle(10); chk("paused_time", timeLeft, 16'h0005);
        chk("paused_run", 16'(running), 16'h0000);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(3);  chk("resume_t3", timeLeft, 16'h0005);
        idle(1);  chk("resume_t4", timeLeft, 16'h0004);
        cyc(0, 0, 0, 1, 0, 16'h0000);
`endif

        // Reset overrides everything while running
        cyc(0, 1, 0, 0, 0, 16'h0043);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        idle(4);  chk("at_0042", timeLeft, 16'h0042);
        cyc(1, 1, 1, 0, 1, 16'h0075);
        chk("rst_run_time", timeLeft, 16'h0000);
        chk("rst_run_running", 16'(running), 16'h0000);
        chk("rst_run_done", 16'(done), 16'h0000);
        chk("rst_run_err", 16'(loadErr), 16'h0000);

        // Random pulse traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, l, s, c, p;
            logic [15:0] d;
            int          k;
            r = ($urandom_range(0, 499) == 0);
            l = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 9) == 0);
            k = int'($urandom_range(0, 7));
            if (k == 0)      d = 16'($urandom);
            else if (k == 1) d = 16'h0000;
            else             d = to_bcd(int'($urandom_range(1, 70)));
            cyc(r, l, s, c, p, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
COOK_TIMER -- requirements
Module: cook_timer

Interface
REQ-001 The block SHALL have parameter TICKS_PER_SEC, default 50000000, giving clock cycles per countdown second (minimum 2).
REQ-002 The block SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have port durationIn  in  16  BCD duration {min tens, min units, sec tens, sec units} from the keypad decoder.
REQ-005 The block SHALL have port load  in  1  single-cycle pulse that captures durationIn (the enter key).
REQ-006 The block SHALL have port start  in  1  single-cycle pulse that begins or resumes the countdown.
REQ-007 The block SHALL have port cancel  in  1  single-cycle pulse that clears the timer.
REQ-008 The block SHALL have port pause  in  1  single-cycle pulse that suspends the countdown (COOK_TIMER_PAUSE_EN only).
REQ-009 The block SHALL have port timeLeft  out  16  current remaining time in the durationIn BCD format.
REQ-010 The block SHALL have port running  out  1  high while counting down (magnetron enable).
REQ-011 The block SHALL have port done  out  1  high while in DONE.
REQ-012 The block SHALL have port loadErr  out  1  one-cycle pulse flagging a rejected load.

Function
REQ-013 States SHALL be IDLE, ARMED, RUN, PAUSED, DONE; running=1 only in RUN; done=1 only in DONE.
REQ-014 load in IDLE, ARMED or DONE with valid BCD (every digit <=9, sec tens <=5) and nonzero value SHALL set timeLeft=durationIn and enter ARMED the next cycle.
REQ-015 load with invalid BCD or value 0000 SHALL leave state and timeLeft unchanged and pulse loadErr for exactly one cycle.
REQ-016 load in RUN or PAUSED SHALL be ignored.
REQ-017 start in ARMED or PAUSED SHALL enter RUN and clear the prescaler to 0; start in any other state SHALL be ignored.
REQ-018 In RUN the prescaler SHALL count 0..TICKS_PER_SEC-1 and wrap; at each wrap timeLeft SHALL decrement by one second, so the first decrement occurs exactly TICKS_PER_SEC cycles after the start edge.
REQ-019 Decrement SHALL be BCD: sec units 0 borrows from sec tens; sec 00 becomes 59 borrowing one minute; minute digits borrow likewise (e.g. 10:00 -> 09:59).
REQ-020 The decrement that produces 0000 SHALL, on the same edge, enter DONE with running=0.
REQ-021 DONE SHALL hold until cancel (-> IDLE, timeLeft=0000) or a valid load (-> ARMED).
REQ-022 cancel in any state SHALL enter IDLE with timeLeft=0000 and prescaler=0 on the next edge.
REQ-023 Priority when pulses coincide SHALL be cancel > pause > start > load.

Reset
REQ-024 On reset: state IDLE, timeLeft=0000, prescaler 0, running=0, done=0, loadErr=0; reset SHALL override all inputs in the same cycle.

Configuration
REQ-025 With macro COOK_TIMER_PAUSE_EN defined, pause in RUN SHALL enter PAUSED, freezing timeLeft and prescaler; start resumes per REQ-017 and pause outside RUN is ignored.
REQ-026 Without COOK_TIMER_PAUSE_EN, port pause SHALL be absent, PAUSED SHALL be unreachable, and the next-state logic SHALL contain no pause term.

Structure
REQ-027 The state encoding, the BCD digit-valid limits (9, 5) and the 16-bit time width SHALL live in the shared microwave package.
REQ-028 BCD validate/decrement SHALL be one combinational sub-module, bcd_time_dec, outputs next-value and valid flag.

Verification (TICKS_PER_SEC=4)
REQ-029 load 0003, start -> running=1; timeLeft 0002/0001/0000 at 4/8/12 cycles after start; done=1 and running=0 at cycle 12.
REQ-030 load 1000, start, 4 cycles -> timeLeft=0959; load 0100 then one tick -> 0059.
REQ-031 load 0075 or 0000 -> loadErr pulses one cycle, state and timeLeft unchanged.
REQ-032 In RUN at 0130 assert cancel with start same cycle -> next cycle IDLE, timeLeft=0000, running=0.
REQ-033 Define COOK_TIMER_PAUSE_EN: load 0005, start, pause after 2 cycles, hold 10 cycles, start -> timeLeft still 0005, first decrement 4 cycles after resume.
REQ-034 Assert reset during RUN at 0042 -> next cycle all outputs at REQ-024 values.
